// File: rtl/slc3_step_ctrl.sv
// Run/Continue button front end and N-step auto-continue controller for an SLC-3 CPU.
// Define STEP_BREAKPOINT_EN to enable the PC breakpoint comparators and the BP_HALT state.
module slc3_step_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned NUM_BP  = 2,
    parameter int unsigned CNT_W   = 10,
    parameter int unsigned DEB_CYC = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run_n,
    input  logic                     Continue_n,
    input  logic [CNT_W-1:0]         SW,
    input  logic                     step_mode,
    input  logic                     cpu_paused,
    input  logic [ADDR_W-1:0]        PC,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]        bp_valid,
    output logic                     Run_out,
    output logic                     Continue_out,
    output logic                     halt_bp,
    output logic [2:0]               bp_hit_idx,
    output logic [CNT_W-1:0]         steps_left
);

    localparam int unsigned DebW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StRunning, StBpHalt} state_e;

    // Button index 0 = Run, 1 = Continue.
    logic [1:0]      sync0_q, sync1_q;
    logic [1:0]      fill_q;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      arm_q, arm_d;
    logic [DebW-1:0] cnt_q [2];
    logic [DebW-1:0] cnt_d [2];
    logic [1:0]      press;
    logic            sync_ok;

    state_e          state_q, state_d;
    logic            run_q, run_d, cont_q, cont_d;
    logic            halt_q, halt_d;
    logic [2:0]      idx_q, idx_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic            paused_q, paused_d;
    logic            pulse_active, pause_rise;
    logic [CNT_W-1:0] sw_load;
    logic            bp_match;
    logic [2:0]      bp_idx;

    // Samples taken before the synchroniser refills after reset are not trusted.
    assign sync_ok = fill_q[1];

    always_comb begin
        deb_d = deb_q;
        arm_d = arm_q;
        cnt_d = cnt_q;
        for (int b = 0; b < 2; b++) begin
            if (sync_ok) begin
                if (sync1_q[b] == deb_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] == DebW'(DEB_CYC - 1)) begin
                    deb_d[b] = sync1_q[b];
                    cnt_d[b] = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + DebW'(1);
                end
                // A button held through reset must be seen released before it may fire.
                if (sync1_q[b]) begin
                    arm_d[b] = 1'b1;
                end
            end
        end
        press = deb_q & ~deb_d & arm_q;
    end

`ifdef STEP_BREAKPOINT_EN
    always_comb begin
        bp_match = 1'b0;
        bp_idx   = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_valid[i] && (bp_addr[i*ADDR_W +: ADDR_W] == PC)) begin
                bp_match = 1'b1;
                bp_idx   = 3'(i);
            end
        end
    end
`else
    logic unused_bp;
    assign unused_bp = ^{bp_addr, bp_valid, PC};
    assign bp_match  = 1'b0;
    assign bp_idx    = '0;
`endif

    assign sw_load      = (SW == '0) ? CNT_W'(1) : SW;
    assign pulse_active = run_q | cont_q;
    // Pause edges are held off while a pulse is out so pulses never abut.
    assign paused_d     = pulse_active ? paused_q : cpu_paused;
    assign pause_rise   = cpu_paused & ~paused_q & ~pulse_active;

    always_comb begin
        state_d = state_q;
        run_d   = 1'b0;
        cont_d  = 1'b0;
        halt_d  = halt_q;
        idx_d   = idx_q;
        steps_d = steps_q;
        unique case (state_q)
            StIdle, StBpHalt: begin
                if (press[0] || press[1]) begin
                    run_d   = press[0];
                    cont_d  = ~press[0];
                    steps_d = sw_load;
                    halt_d  = 1'b0;
                    state_d = StRunning;
                end
            end
            StRunning: begin
                if (pause_rise) begin
                    if (bp_match) begin
                        halt_d  = 1'b1;
                        idx_d   = bp_idx;
                        state_d = StBpHalt;
                    end else if (step_mode && (steps_q > CNT_W'(1))) begin
                        steps_d = steps_q - CNT_W'(1);
                        cont_d  = 1'b1;
                    end else begin
                        steps_d = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync0_q  <= 2'b11;
            sync1_q  <= 2'b11;
            fill_q   <= 2'b00;
            deb_q    <= 2'b11;
            arm_q    <= 2'b00;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            state_q  <= StIdle;
            run_q    <= 1'b0;
            cont_q   <= 1'b0;
            halt_q   <= 1'b0;
            idx_q    <= '0;
            steps_q  <= '0;
            paused_q <= 1'b0;
        end else begin
            sync0_q  <= {Continue_n, Run_n};
            sync1_q  <= sync0_q;
            fill_q   <= {fill_q[0], 1'b1};
            deb_q    <= deb_d;
            arm_q    <= arm_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            run_q    <= run_d;
            cont_q   <= cont_d;
            halt_q   <= halt_d;
            idx_q    <= idx_d;
            steps_q  <= steps_d;
            paused_q <= paused_d;
        end
    end

    assign Run_out      = run_q;
    assign Continue_out = cont_q;
    assign halt_bp      = halt_q;
    assign bp_hit_idx   = idx_q;
    assign steps_left   = steps_q;

endmodule

// File: tb/tb_slc3_step_ctrl.sv
// Directed bench for slc3_step_ctrl: vector table for press/pause behaviour plus
// hand sequences for debounce, N-step, breakpoint and reset corner cases.
module tb_slc3_step_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Run_n;
    logic        Continue_n;
    logic [9:0]  SW;
    logic        step_mode;
    logic        cpu_paused;
    logic [15:0] PC;
    logic [31:0] bp_addr;
    logic [1:0]  bp_valid;
    logic        Run_out;
    logic        Continue_out;
    logic        halt_bp;
    logic [2:0]  bp_hit_idx;
    logic [9:0]  steps_left;

    slc3_step_ctrl #(
        .ADDR_W (16),
        .NUM_BP (2),
        .CNT_W  (10),
        .DEB_CYC(4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run_n       (Run_n),
        .Continue_n  (Continue_n),
        .SW          (SW),
        .step_mode   (step_mode),
        .cpu_paused  (cpu_paused),
        .PC          (PC),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .Run_out     (Run_out),
        .Continue_out(Continue_out),
        .halt_bp     (halt_bp),
        .bp_hit_idx  (bp_hit_idx),
        .steps_left  (steps_left)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_run    = 0;
    int n_cont   = 0;
    int n_viol   = 0;
    logic prev_pulse = 1'b0;

    typedef struct {
        logic [9:0] sw;
        logic       mode;
        logic       run;
        logic       cont;
        int         exp_run;
        int         exp_cont;
        int         exp_steps;
        int         exp_cont2;
        int         exp_steps2;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        if (Run_out) n_run++;
        if (Continue_out) n_cont++;
        if ((Run_out && Continue_out) || ((Run_out || Continue_out) && prev_pulse)) n_viol++;
        prev_pulse = Run_out || Continue_out;
    endtask

    task automatic clear_counts();
        n_run  = 0;
        n_cont = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        repeat (4) tick();
    endtask

    task automatic press(input logic run, input logic cont, input int hold);
        Run_n      = ~run;
        Continue_n = ~cont;
        repeat (hold) tick();
        Run_n      = 1'b1;
        Continue_n = 1'b1;
        repeat (10) tick();
    endtask

    task automatic pause(input int hold);
        cpu_paused = 1'b1;
        repeat (hold) tick();
        cpu_paused = 1'b0;
        repeat (3) tick();
    endtask

    int exp_halt, exp_idx, exp_c, exp_s, exp_halt2, exp_c2, exp_s2;

    initial begin
        vecs[0] = '{10'd3,    1'b1, 1'b1, 1'b0, 1, 0, 3,    1, 2};
        vecs[1] = '{10'd0,    1'b1, 1'b0, 1'b1, 0, 1, 1,    0, 0};
        vecs[2] = '{10'd5,    1'b0, 1'b1, 1'b0, 1, 0, 5,    0, 0};
        vecs[3] = '{10'd2,    1'b1, 1'b1, 1'b1, 1, 0, 2,    1, 1};
        vecs[4] = '{10'd1,    1'b1, 1'b0, 1'b1, 0, 1, 1,    0, 0};
        vecs[5] = '{10'd1023, 1'b1, 1'b0, 1'b1, 0, 1, 1023, 1, 1022};

        Reset      = 1'b1;
        Run_n      = 1'b1;
        Continue_n = 1'b1;
        SW         = '0;
        step_mode  = 1'b0;
        cpu_paused = 1'b0;
        PC         = 16'h3000;
        bp_addr    = '0;
        bp_valid   = '0;
        do_reset();

        check("reset_run_out", int'(Run_out), 0);
        check("reset_cont_out", int'(Continue_out), 0);
        check("reset_halt", int'(halt_bp), 0);
        check("reset_idx", int'(bp_hit_idx), 0);
        check("reset_steps", int'(steps_left), 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            SW        = vecs[i].sw;
            step_mode = vecs[i].mode;
            clear_counts();
            press(vecs[i].run, vecs[i].cont, 10);
            check($sformatf("vec%0d_run", i), n_run, vecs[i].exp_run);
            check($sformatf("vec%0d_cont", i), n_cont, vecs[i].exp_cont);
            check($sformatf("vec%0d_steps", i), int'(steps_left), vecs[i].exp_steps);
            clear_counts();
            pause(3);
            check($sformatf("vec%0d_pause_cont", i), n_cont, vecs[i].exp_cont2);
            check($sformatf("vec%0d_pause_steps", i), int'(steps_left), vecs[i].exp_steps2);
        end

        // Debounce boundary: 3-cycle glitch rejected, 4-cycle low accepted.
        do_reset();
        SW = 10'd1;
        step_mode = 1'b1;
        clear_counts();
        press(1'b1, 1'b0, 3);
        check("glitch3_run", n_run, 0);
        clear_counts();
        press(1'b1, 1'b0, 4);
        check("low4_run", n_run, 1);
        pause(3);

        // N-step run of three with a held pause that must not retrigger.
        do_reset();
        SW = 10'd3;
        step_mode = 1'b1;
        clear_counts();
        press(1'b1, 1'b0, 12);
        check("nstep_run", n_run, 1);
        check("nstep_steps0", int'(steps_left), 3);
        cpu_paused = 1'b1;
        tick();
        check("nstep_cont_edge", int'(Continue_out), 1);
        tick();
        check("nstep_cont_one_cycle", int'(Continue_out), 0);
        repeat (10) tick();
        cpu_paused = 1'b0;
        repeat (3) tick();
        check("nstep_steps1", int'(steps_left), 2);
        pause(3);
        check("nstep_steps2", int'(steps_left), 1);
        press(1'b0, 1'b1, 10);
        check("nstep_ignore_press", n_cont, 2);
        pause(3);
        check("nstep_steps3", int'(steps_left), 0);
        check("nstep_cont_total", n_cont, 2);
        check("nstep_run_total", n_run, 1);
        clear_counts();
        press(1'b0, 1'b1, 10);
        check("nstep_idle_cont", n_cont, 1);
        pause(3);

        // Breakpoint on entry 1; entry 0 holds the same address but is not valid.
`ifdef STEP_BREAKPOINT_EN
        exp_halt = 1; exp_idx = 1; exp_c = 0; exp_s = 5;
        exp_halt2 = 0; exp_c2 = 1; exp_s2 = 5;
`else
        exp_halt = 0; exp_idx = 0; exp_c = 1; exp_s = 4;
        exp_halt2 = 0; exp_c2 = 0; exp_s2 = 4;
`endif
        do_reset();
        SW       = 10'd5;
        step_mode = 1'b1;
        bp_addr  = {16'h3005, 16'h3005};
        bp_valid = 2'b10;
        PC       = 16'h3005;
        press(1'b1, 1'b0, 10);
        clear_counts();
        pause(3);
        check("bp_halt", int'(halt_bp), exp_halt);
        check("bp_idx", int'(bp_hit_idx), exp_idx);
        check("bp_cont", n_cont, exp_c);
        check("bp_steps", int'(steps_left), exp_s);
        clear_counts();
        press(1'b0, 1'b1, 10);
        check("bp_resume_halt", int'(halt_bp), exp_halt2);
        check("bp_resume_cont", n_cont, exp_c2);
        check("bp_resume_steps", int'(steps_left), exp_s2);
        bp_valid = 2'b00;
        PC       = 16'h3000;

        // Reset while running with four steps left.
        do_reset();
        SW = 10'd4;
        step_mode = 1'b1;
        press(1'b1, 1'b0, 10);
        check("rst_pre_steps", int'(steps_left), 4);
        Reset = 1'b1;
        tick();
        check("rst_mid_steps", int'(steps_left), 0);
        check("rst_mid_run", int'(Run_out), 0);
        check("rst_mid_cont", int'(Continue_out), 0);
        check("rst_mid_halt", int'(halt_bp), 0);
        Reset = 1'b0;
        repeat (4) tick();
        clear_counts();
        press(1'b0, 1'b1, 10);
        check("rst_then_idle_cont", n_cont, 1);
        pause(3);

        // Button held across reset fires only after a release and new press.
        Run_n = 1'b0;
        repeat (8) tick();
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        clear_counts();
        repeat (20) tick();
        check("held_rst_no_run", n_run, 0);
        Run_n = 1'b1;
        repeat (12) tick();
        check("held_rst_release_run", n_run, 0);
        press(1'b1, 1'b0, 10);
        check("held_rst_repress_run", n_run, 1);

        check("pulse_rules", n_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
